// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares the single common data bus (CDB) between the execution units.
//   Each cycle one eligible requester is picked round-robin and receives a
//   one-hot combinational grant. The granted unit retires its reservation
//   station entry on the same edge. The winner's tag/result is registered and
//   broadcast on the bus one cycle later for the RS / register-status snoopers.
//
// Ports
//   clk          in   rising-edge system clock
//   rst          in   synchronous reset, active-low
//   flush        in   branch mispredict: squashes this cycle's grant/broadcast
//   req_valid    in   [N_REQ]         unit i has a completed result
//   req_index    in   [N_REQ*LOCK_W]  unit i tag in [i*LOCK_W +: LOCK_W]
//   req_result   in   [N_REQ*DATA_W]  unit i result in [i*DATA_W +: DATA_W]
//   grnt         out  [N_REQ]         one-hot grant, combinational
//   cdb_valid    out  broadcast valid (registered)
//   cdb_index    out  [LOCK_W] broadcast tag, NO_LOCK when idle (registered)
//   cdb_result   out  [DATA_W] broadcast data (registered, holds when idle)
//   cdb_busy_cnt out  [32] saturating count of cycles with cdb_valid=1
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int                N_REQ   = 4,
  parameter int                LOCK_W  = 5,
  parameter int                DATA_W  = 32,
  parameter logic [LOCK_W-1:0] NO_LOCK = {LOCK_W{1'b0}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*LOCK_W-1:0]   req_index,
  input  logic [N_REQ*DATA_W-1:0]   req_result,
  output logic [N_REQ-1:0]          grnt,
  output logic                      cdb_valid,
  output logic [LOCK_W-1:0]         cdb_index,
  output logic [DATA_W-1:0]         cdb_result,
  output logic [31:0]               cdb_busy_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // (base + off) mod N_REQ, valid for off in [0, N_REQ]
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input int off);
    int sum;
    sum = int'(base) + off;
    sum = (sum >= N_REQ) ? (sum - N_REQ) : sum;
    return PTR_W'(sum);
  endfunction

  logic [PTR_W-1:0]  rr_ptr_r;
  logic              cdb_valid_r;
  logic [LOCK_W-1:0] cdb_index_r;
  logic [DATA_W-1:0] cdb_result_r;
  logic [31:0]       busy_cnt_r;

  logic [N_REQ-1:0]  elig_s;
  logic [N_REQ-1:0]  grnt_s;
  logic [PTR_W-1:0]  win_s;
  logic [PTR_W-1:0]  cand_s;
  logic              found_s;
  logic              hit_s;
  logic              grant_any_s;
  logic [PTR_W-1:0]  nxt_ptr_s;
  logic [LOCK_W-1:0] win_index_s;
  logic [DATA_W-1:0] win_result_s;

  // A request carrying the "no lock" tag has nothing to broadcast, so it is
  // never eligible.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig_s[i] = req_valid[i] && (req_index[i*LOCK_W +: LOCK_W] != NO_LOCK);
    end
  end

  // Round-robin search starting at rr_ptr, ascending with wrap; first hit wins.
  always_comb begin
    grnt_s  = '0;
    win_s   = '0;
    cand_s  = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    if (!rst || flush) begin
      grnt_s = '0;
      win_s  = '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        cand_s          = wrap_add(rr_ptr_r, k);
        hit_s           = !found_s && elig_s[cand_s];
        grnt_s[cand_s]  = grnt_s[cand_s] | hit_s;
        win_s           = hit_s ? cand_s : win_s;
        found_s         = found_s | hit_s;
      end
    end
  end

  // Winner payload mux: grnt_s is one-hot or zero, so an AND-OR mux suffices.
  always_comb begin
    win_index_s  = '0;
    win_result_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_index_s  = win_index_s  | (req_index[i*LOCK_W +: LOCK_W]  & {LOCK_W{grnt_s[i]}});
      win_result_s = win_result_s | (req_result[i*DATA_W +: DATA_W] & {DATA_W{grnt_s[i]}});
    end
  end

  assign grant_any_s = |grnt_s;
  assign nxt_ptr_s   = wrap_add(win_s, 1);

  // Round-robin pointer: move just past the winner, hold when nothing granted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_r <= '0;
    end else if (grant_any_s) begin
      rr_ptr_r <= nxt_ptr_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Broadcast register: one-cycle latency from grant; result holds when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cdb_valid_r  <= 1'b0;
      cdb_index_r  <= NO_LOCK;
      cdb_result_r <= '0;
    end else if (grant_any_s) begin
      cdb_valid_r  <= 1'b1;
      cdb_index_r  <= win_index_s;
      cdb_result_r <= win_result_s;
    end else begin
      cdb_valid_r  <= 1'b0;
      cdb_index_r  <= NO_LOCK;
      cdb_result_r <= cdb_result_r;
    end
  end

  // Bus-occupancy counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_cnt_r <= 32'd0;
    end else if (cdb_valid_r && (busy_cnt_r != 32'hFFFF_FFFF)) begin
      busy_cnt_r <= busy_cnt_r + 32'd1;
    end else begin
      busy_cnt_r <= busy_cnt_r;
    end
  end

  assign grnt         = grnt_s;
  assign cdb_valid    = cdb_valid_r;
  assign cdb_index    = cdb_index_r;
  assign cdb_result   = cdb_result_r;
  assign cdb_busy_cnt = busy_cnt_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Directed vectors with hand-computed grants and counter values. The stimulus
//   pushes expectations into queues; a negedge monitor pops and compares them
//   against whatever the DUT presents on grnt and the broadcast bus.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int N = 4;
  localparam int LW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*LW-1:0] req_index;
  logic [N*DW-1:0] req_result;
  logic [N-1:0]    grnt;
  logic            cdb_valid;
  logic [LW-1:0]   cdb_index;
  logic [DW-1:0]   cdb_result;
  logic [31:0]     cdb_busy_cnt;

  logic [LW-1:0] idx_a [N];
  logic [DW-1:0] res_a [N];

  typedef struct { int cyc; logic [N-1:0] grnt; int cnt; } gexp_t;
  typedef struct { int cyc; logic [LW-1:0] idx; logic [DW-1:0] res; } bexp_t;

  gexp_t gq[$];
  bexp_t bq[$];

  int  n_chk   = 0;
  int  n_pass  = 0;
  int  n_fail  = 0;
  int  tb_cycle = 0;
  bit  started = 1'b0;

  cdb_arbiter #(.N_REQ(N), .LOCK_W(LW), .DATA_W(DW), .NO_LOCK(5'd0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_index(req_index), .req_result(req_result),
    .grnt(grnt), .cdb_valid(cdb_valid), .cdb_index(cdb_index),
    .cdb_result(cdb_result), .cdb_busy_cnt(cdb_busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tb_cycle <= tb_cycle + 1;

  always_comb begin
    req_index  = '0;
    req_result = '0;
    for (int i = 0; i < N; i++) begin
      req_index[i*LW +: LW]  = idx_a[i];
      req_result[i*DW +: DW] = res_a[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, tb_cycle);
    end
  endtask

  // One clock of stimulus: drive inputs, queue the hand-computed expectations.
  task automatic step(input bit r, input bit f, input logic [N-1:0] v,
                      input logic [N-1:0] eg, input int ecnt);
    gexp_t g;
    bexp_t b;
    started   = 1'b1;
    rst       = r;
    flush     = f;
    req_valid = v;
    g.cyc = tb_cycle; g.grnt = eg; g.cnt = ecnt;
    gq.push_back(g);
    for (int i = 0; i < N; i++) begin
      if (eg[i]) begin
        b.cyc = tb_cycle + 1; b.idx = idx_a[i]; b.res = res_a[i];
        bq.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare grant, counter and broadcast bus mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      if (gq.size() > 0) begin
        gexp_t g;
        g = gq.pop_front();
        chk("stamp", tb_cycle, g.cyc);
        chk("grnt", {28'd0, grnt}, {28'd0, g.grnt});
        if (g.cnt >= 0) chk("busy_cnt", cdb_busy_cnt, g.cnt);
      end
      begin
        bit exp_v;
        exp_v = (bq.size() > 0) && (bq[0].cyc == tb_cycle);
        chk("cdb_valid", {31'd0, cdb_valid}, {31'd0, exp_v});
        if (exp_v) begin
          bexp_t b;
          b = bq.pop_front();
          chk("cdb_index", {27'd0, cdb_index}, {27'd0, b.idx});
          chk("cdb_result", cdb_result, b.res);
        end else begin
          chk("cdb_index_idle", {27'd0, cdb_index}, 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [3:0] F = 4'b1111;

  initial begin
    rst = 1'b0; flush = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      idx_a[i] = LW'(10 + i);
      res_a[i] = 32'h1000_0000 + 32'(i);
    end
    @(posedge clk); #1;

    // reset held with all requests
    step(1'b0, 1'b0, F, 4'b0000, 0);
    step(1'b0, 1'b0, F, 4'b0000, 0);
    // release, then round-robin over all four (8 grants)
    step(1'b1, 1'b0, F, 4'b0001, 0);
    step(1'b1, 1'b0, F, 4'b0010, 0);
    step(1'b1, 1'b0, F, 4'b0100, 1);
    step(1'b1, 1'b0, F, 4'b1000, 2);
    step(1'b1, 1'b0, F, 4'b0001, 3);
    step(1'b1, 1'b0, F, 4'b0010, 4);
    step(1'b1, 1'b0, F, 4'b0100, 5);
    step(1'b1, 1'b0, F, 4'b1000, 6);
    // grant unit 1 so rr_ptr=2, then wrap to unit 0, then unit 1
    step(1'b1, 1'b0, 4'b0010, 4'b0010, 7);
    step(1'b1, 1'b0, 4'b0011, 4'b0001, 8);
    step(1'b1, 1'b0, 4'b0011, 4'b0010, 9);
    // NO_LOCK tag is never granted
    idx_a[1] = 5'd0;
    step(1'b1, 1'b0, 4'b0010, 4'b0000, 10);
    step(1'b1, 1'b0, 4'b0011, 4'b0001, 11);
    idx_a[1] = 5'd11;
    // flush squashes grant; pending broadcast still appears
    idx_a[2] = 5'd7;
    res_a[2] = 32'hDEAD_BEEF;
    step(1'b1, 1'b1, 4'b0100, 4'b0000, 11);
    step(1'b1, 1'b0, 4'b0100, 4'b0100, 12);
    step(1'b1, 1'b0, 4'b0010, 4'b0010, 12);
    // mid-stream reset with a broadcast registered; rr_ptr was 2
    step(1'b0, 1'b0, F, 4'b0000, 13);
    step(1'b1, 1'b0, F, 4'b0001, 0);
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 0);
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 1);
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 1);

    @(negedge clk);
    #1;
    chk("gq_drained", 32'(gq.size()), 32'd0);
    chk("bq_drained", 32'(bq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
